// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_WAIT  = 2'd1,
        FETCH_HOLD  = 2'd2,
        FETCH_DRAIN = 2'd3
    } fetch_state_t;

    // Word presented to decode when the PC is misaligned.
    localparam logic [31:0] FETCH_FAULT_WORD = 32'h0;

    function automatic logic is_aligned(input logic [1:0] pc_lsbs);
        return pc_lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_reg.sv
// Load-enabled register with synchronous active-low reset to a fixed value.
module instr_fetch_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch sequencer: one imem read per PC, result buffered for decode, PC advanced on accept.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int               DBITS    = 32,
    parameter logic [DBITS-1:0] START_PC = DBITS'(64)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] pcIn,
    output logic             pcAdvance,
    input  logic             flush,
    output logic             imemReq,
    output logic [DBITS-1:0] imemAddr,
    input  logic             imemAck,
    input  logic [DBITS-1:0] imemRdata,
    output logic             instValid,
    input  logic             instReady,
    output logic [DBITS-1:0] instWord,
    output logic [DBITS-1:0] instPc,
    output logic             instFault
);

    fetch_state_t state, state_nxt;

    logic               req_nxt;
    logic               valid_nxt;
    logic               fault_nxt;
    logic               req_pc_en;
    logic               buf_en;
    logic [DBITS-1:0]   req_pc;
    logic [2*DBITS-1:0] buf_d;
    logic [2*DBITS-1:0] buf_q;

    instr_fetch_reg #(
        .WIDTH     (DBITS),
        .RESET_VAL (START_PC)
    ) u_req_pc (
        .clk   (clk),
        .reset (reset),
        .en    (req_pc_en),
        .d     (pcIn),
        .q     (req_pc)
    );

    // Output buffer holds {instWord, instPc}.
    instr_fetch_reg #(
        .WIDTH     (2*DBITS),
        .RESET_VAL ({DBITS'(FETCH_FAULT_WORD), START_PC})
    ) u_inst_buf (
        .clk   (clk),
        .reset (reset),
        .en    (buf_en),
        .d     (buf_d),
        .q     (buf_q)
    );

    assign {instWord, instPc} = buf_q;
    assign imemAddr           = req_pc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= FETCH_IDLE;
            imemReq   <= 1'b0;
            instValid <= 1'b0;
            instFault <= 1'b0;
        end else begin
            state     <= state_nxt;
            imemReq   <= req_nxt;
            instValid <= valid_nxt;
            instFault <= fault_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_nxt = state;
        req_nxt   = imemReq;
        valid_nxt = instValid;
        fault_nxt = instFault;
        req_pc_en = 1'b0;
        buf_en    = 1'b0;
        buf_d     = {imemRdata, req_pc};
        pcAdvance = 1'b0;

        unique case (state)
            FETCH_IDLE: begin
                if (!flush) begin
                    if (is_aligned(pcIn[1:0])) begin
                        req_pc_en = 1'b1;
                        req_nxt   = 1'b1;
                        state_nxt = FETCH_WAIT;
                    end else begin
                        buf_en    = 1'b1;
                        buf_d     = {DBITS'(FETCH_FAULT_WORD), pcIn};
                        fault_nxt = 1'b1;
                        valid_nxt = 1'b1;
                        state_nxt = FETCH_HOLD;
                    end
                end
            end
            FETCH_WAIT: begin
                if (flush) begin
                    // A flushed request must still see its ack before the next one goes out.
                    if (imemAck) begin
                        req_nxt   = 1'b0;
                        state_nxt = FETCH_IDLE;
                    end else begin
                        state_nxt = FETCH_DRAIN;
                    end
                end else if (imemAck) begin
                    buf_en    = 1'b1;
                    fault_nxt = 1'b0;
                    valid_nxt = 1'b1;
                    req_nxt   = 1'b0;
                    state_nxt = FETCH_HOLD;
                end
            end
            FETCH_DRAIN: begin
                if (imemAck) begin
                    req_nxt   = 1'b0;
                    state_nxt = FETCH_IDLE;
                end
            end
            FETCH_HOLD: begin
                pcAdvance = instValid & instReady & ~flush;
                if (flush || instReady) begin
                    valid_nxt = 1'b0;
                    fault_nxt = 1'b0;
                    state_nxt = FETCH_IDLE;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a transaction-level reference model and PC/imem environment.
module tb_instr_fetch;

    localparam logic [31:0] START_PC = 32'd64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pcIn = START_PC;
    logic        pcAdvance;
    logic        flush = 1'b0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck = 1'b0;
    logic [31:0] imemRdata = 32'h0;
    logic        instValid;
    logic        instReady = 1'b0;
    logic [31:0] instWord;
    logic [31:0] instPc;
    logic        instFault;

    instr_fetch #(.DBITS(32), .START_PC(START_PC)) dut (
        .clk       (clk),
        .reset     (reset),
        .pcIn      (pcIn),
        .pcAdvance (pcAdvance),
        .flush     (flush),
        .imemReq   (imemReq),
        .imemAddr  (imemAddr),
        .imemAck   (imemAck),
        .imemRdata (imemRdata),
        .instValid (instValid),
        .instReady (instReady),
        .instWord  (instWord),
        .instPc    (instPc),
        .instFault (instFault)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what the fetcher currently owns (an outstanding read, or a buffered instruction).
    typedef struct {
        logic        req;
        logic        dead;
        logic        holding;
        logic        fault;
        logic [31:0] addr;
        logic [31:0] word;
        logic [31:0] pc;
    } model_t;

    model_t m;

    function automatic model_t model_step(input model_t c, input logic rst_n, input logic fl,
                                          input logic ack, input logic rdy,
                                          input logic [31:0] pc, input logic [31:0] rdata);
        model_t n = c;
        if (!rst_n) begin
            n.req = 1'b0; n.dead = 1'b0; n.holding = 1'b0; n.fault = 1'b0;
            n.addr = START_PC; n.word = 32'h0; n.pc = START_PC;
        end else if (c.holding) begin
            if (fl || rdy) begin
                n.holding = 1'b0;
                n.fault   = 1'b0;
            end
        end else if (c.req) begin
            if (ack) begin
                n.req = 1'b0;
                if (!c.dead && !fl) begin
                    n.holding = 1'b1; n.word = rdata; n.pc = c.addr; n.fault = 1'b0;
                end
            end else if (fl) begin
                n.dead = 1'b1;
            end
        end else if (!fl) begin
            if (pc[1:0] == 2'b00) begin
                n.req = 1'b1; n.dead = 1'b0; n.addr = pc;
            end else begin
                n.holding = 1'b1; n.word = 32'h0; n.pc = pc; n.fault = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk)
        m <= model_step(m, reset, flush, imemAck, instReady, pcIn, imemRdata);

    always @(negedge clk) begin
        check1("imemReq", imemReq, m.req);
        check32("imemAddr", imemAddr, m.addr);
        check1("instValid", instValid, m.holding);
        check1("pcAdvance", pcAdvance, m.holding & instReady & ~flush);
        if (m.holding) begin
            check32("instWord", instWord, m.word);
            check32("instPc", instPc, m.pc);
            check1("instFault", instFault, m.fault);
        end
    end

    // Environment: PC register and instruction memory with configurable latency.
    int          mem_lat     = 1;
    int          req_age     = 0;
    int          adv_count   = 0;
    int          valid_cycles = 0;
    logic [31:0] flush_target = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'd64) ? 32'hDEADBEEF : (32'hC0DE_0000 | a);
    endfunction

    task automatic tick();
        logic adv;
        @(negedge clk);
        adv = pcAdvance;
        adv_count    += int'(adv);
        valid_cycles += int'(instValid);
        @(posedge clk);
        #1;
        if (!reset)     pcIn = START_PC;
        else if (flush) pcIn = flush_target;
        else if (adv)   pcIn = pcIn + 32'd4;
        if (!reset || !imemReq) begin
            req_age = 0;
            imemAck = 1'b0;
        end else begin
            req_age++;
            imemAck = (req_age == mem_lat);
        end
        imemRdata = mem_word(imemAddr);
    endtask

    task automatic check_reset(input string tag);
        check1({tag, "_imemReq"}, imemReq, 1'b0);
        check32({tag, "_imemAddr"}, imemAddr, START_PC);
        check1({tag, "_instValid"}, instValid, 1'b0);
        check32({tag, "_instWord"}, instWord, 32'h0);
        check32({tag, "_instPc"}, instPc, START_PC);
        check1({tag, "_instFault"}, instFault, 1'b0);
        check1({tag, "_pcAdvance"}, pcAdvance, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int v0;

        // Reset, then L=1 fetch of DEADBEEF at 64 with instReady high.
        tick(); tick();
        check_reset("rst0");
        reset = 1'b1; instReady = 1'b1; mem_lat = 1;
        tick();
        check1("s1_req", imemReq, 1'b1);
        check32("s1_addr", imemAddr, 32'd64);
        a0 = adv_count;
        tick();
        check1("s1_valid", instValid, 1'b1);
        check32("s1_word", instWord, 32'hDEADBEEF);
        check32("s1_pc", instPc, 32'd64);
        check1("s1_fault", instFault, 1'b0);
        tick(); tick();
        check1("s1_req2", imemReq, 1'b1);
        check32("s1_addr2", imemAddr, 32'd68);
        check32("s1_adv_pulses", 32'(adv_count - a0), 32'd1);

        // L=3 with decode stalled for 5 cycles.
        tick(); tick();
        mem_lat = 3; instReady = 1'b0;
        for (int i = 0; i < 20 && !instValid; i++) tick();
        check1("s2_valid", instValid, 1'b1);
        check32("s2_pc", instPc, 32'd72);
        check32("s2_word", instWord, 32'hC0DE0048);
        a0 = adv_count;
        for (int i = 0; i < 5; i++) begin
            tick();
            check32("s2_hold_word", instWord, 32'hC0DE0048);
            check32("s2_hold_pc", instPc, 32'd72);
        end
        check32("s2_no_adv", 32'(adv_count - a0), 32'd0);
        instReady = 1'b1;
        tick();
        check32("s2_one_adv", 32'(adv_count - a0), 32'd1);
        tick();
        check32("s2_still_one", 32'(adv_count - a0), 32'd1);

        // Flush in first WAIT cycle of an L=3 read; redirect to 200.
        check1("s3_req", imemReq, 1'b1);
        check32("s3_addr", imemAddr, 32'd76);
        flush = 1'b1; flush_target = 32'd200;
        v0 = valid_cycles;
        tick();
        flush = 1'b0;
        check1("s3_drain_req1", imemReq, 1'b1);
        tick();
        check1("s3_drain_req2", imemReq, 1'b1);
        tick();
        check1("s3_drain_done", imemReq, 1'b0);
        tick();
        check1("s3_new_req", imemReq, 1'b1);
        check32("s3_new_addr", imemAddr, 32'd200);
        check32("s3_no_valid", 32'(valid_cycles - v0), 32'd0);

        // Flush coinciding with imemAck.
        for (int i = 0; i < 20 && !imemAck; i++) tick();
        check1("s4a_req_at_ack", imemReq, 1'b1);
        flush = 1'b1; flush_target = 32'd300;
        v0 = valid_cycles; a0 = adv_count;
        tick();
        flush = 1'b0;
        check1("s4a_req_dropped", imemReq, 1'b0);
        tick();
        check1("s4a_new_req", imemReq, 1'b1);
        check32("s4a_new_addr", imemAddr, 32'd300);
        check32("s4a_no_valid", 32'(valid_cycles - v0), 32'd0);
        check32("s4a_no_adv", 32'(adv_count - a0), 32'd0);

        // Flush in HOLD with instReady high.
        instReady = 1'b0;
        for (int i = 0; i < 20 && !instValid; i++) tick();
        check32("s4b_pc", instPc, 32'd300);
        instReady = 1'b1; flush = 1'b1; flush_target = 32'd400;
        #1;
        check1("s4b_adv_blocked", pcAdvance, 1'b0);
        a0 = adv_count;
        tick();
        flush = 1'b0;
        check1("s4b_valid_drop", instValid, 1'b0);
        check32("s4b_no_adv", 32'(adv_count - a0), 32'd0);
        tick();
        check1("s4b_new_req", imemReq, 1'b1);
        check32("s4b_new_addr", imemAddr, 32'd400);

        // Misaligned target 66.
        instReady = 1'b0;
        for (int i = 0; i < 20 && !instValid; i++) tick();
        flush = 1'b1; flush_target = 32'd66;
        tick();
        flush = 1'b0;
        tick();
        check1("s5_no_req", imemReq, 1'b0);
        check1("s5_valid", instValid, 1'b1);
        check1("s5_fault", instFault, 1'b1);
        check32("s5_word", instWord, 32'h0);
        check32("s5_pc", instPc, 32'd66);
        instReady = 1'b1;
        #1;
        check1("s5_adv", pcAdvance, 1'b1);
        a0 = adv_count;
        tick();
        check32("s5_adv_count", 32'(adv_count - a0), 32'd1);
        flush = 1'b1; flush_target = 32'd500;
        tick();
        flush = 1'b0;
        tick();
        check1("s5_realign_req", imemReq, 1'b1);
        check32("s5_realign_addr", imemAddr, 32'd500);

        // Reset while in WAIT.
        reset = 1'b0;
        tick();
        check_reset("rst_wait");
        reset = 1'b1;
        tick();
        check1("s6_req", imemReq, 1'b1);
        check32("s6_addr", imemAddr, START_PC);

        // Reset while in DRAIN.
        flush = 1'b1; flush_target = 32'd600;
        tick();
        flush = 1'b0;
        check1("s7_drain_req", imemReq, 1'b1);
        reset = 1'b0;
        tick();
        check_reset("rst_drain");
        reset = 1'b1;
        tick();
        check1("s7_req", imemReq, 1'b1);
        check32("s7_addr", imemAddr, START_PC);
        for (int i = 0; i < 20 && !instValid; i++) tick();
        check32("s7_word", instWord, 32'hDEADBEEF);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer at the instruction-memory end of the program counter. It samples the current PC from the PC register and issues one word-read request to instruction memory using a req/ack handshake. It buffers the returned word for decode behind a valid/ready handshake. When decode accepts the word, it pulses the PC register's write enable, so the PC advances exactly once per accepted instruction. Redirects (taken branch, JAL) are absorbed by a flush input that discards any in-flight or buffered fetch.

## Interface
- DBITS, 32, datapath/address width
- START_PC, 64, reset value of captured PC (matches PC register reset)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low (reset==0 resets all state on the next clk edge)
- pcIn  input  DBITS  current PC register output
- pcAdvance  output  1  PC register write enable; single-cycle pulse
- flush  input  1  redirect: PC register is being loaded with a new target this cycle
- imemReq  output  1  read request, registered
- imemAddr  output  DBITS  read address, registered, stable while imemReq=1
- imemAck  input  1  single-cycle pulse; imemRdata valid this cycle
- imemRdata  input  DBITS  read data
- instValid  output  1  instWord/instPc valid, registered
- instReady  input  1  decode accepts when instValid & instReady
- instWord  output  DBITS  fetched instruction
- instPc  output  DBITS  address instWord was fetched from
- instFault  output  1  qualifies instValid: misaligned PC, instWord forced to 0

## Operation
- FSM states: FETCH_IDLE, FETCH_WAIT, FETCH_HOLD, FETCH_DRAIN. Reset state is FETCH_IDLE.
- FETCH_IDLE, aligned case (pcIn[1:0]==0):
  - reqPc<=pcIn, imemAddr<=pcIn, imemReq<=1.
  - Next state FETCH_WAIT.
- FETCH_IDLE, misaligned case:
  - No request is issued.
  - instWord<=0, instPc<=pcIn, instFault<=1, instValid<=1.
  - Next state FETCH_HOLD.
- FETCH_IDLE with flush=1: stay in FETCH_IDLE, issue nothing. The new PC is sampled next cycle.
- FETCH_WAIT:
  - imemReq stays 1, imemAddr stays reqPc.
  - On imemAck & ~flush: instWord<=imemRdata, instPc<=reqPc, instFault<=0, instValid<=1, imemReq<=0. Next state FETCH_HOLD.
- FETCH_WAIT with flush:
  - flush & imemAck (same cycle): data is discarded, imemReq<=0, next state FETCH_IDLE.
  - flush & ~imemAck: next state FETCH_DRAIN, with imemReq held at 1 as the protocol requires.
- FETCH_DRAIN:
  - imemReq=1 until imemAck. On ack, data is discarded, imemReq<=0, next state FETCH_IDLE.
  - Further flushes have no additional effect.
- FETCH_HOLD:
  - pcAdvance = instValid & instReady & ~flush (combinational).
  - On acceptance: instValid<=0, instFault<=0, next state FETCH_IDLE.
  - flush: instValid<=0, no pcAdvance, next state FETCH_IDLE.
  - instReady=0 and no flush: hold all outputs indefinitely.
- pcAdvance is 0 in every state other than FETCH_HOLD.
- imemAck is ignored in FETCH_IDLE and FETCH_HOLD. Instruction memory shares reset, so no stray ack outlives a reset.
- No address arithmetic is done here; PC increment and target selection remain in the PC register path.

## Timing
- Reset outputs: imemReq=0, imemAddr=START_PC, instValid=0, instWord=0, instPc=START_PC, instFault=0, pcAdvance=0.
- First reset-released cycle (state FETCH_IDLE): imemReq rises at the following edge.
- imemAck is legal no earlier than the cycle after imemReq first reads 1 (memory latency L≥1).
- Data latency:
  - Ack in cycle t → instValid=1 in cycle t+1.
  - Acceptance in cycle u → pcAdvance in cycle u, new pcIn in cycle u+1, sampled in FETCH_IDLE in cycle u+1.
- Back-to-back throughput with instReady held at 1: one instruction per L+2 cycles.
- Reset asserted in any state: all outputs return to reset values at the next edge, including mid-request and mid-drain.
- flush has priority over instReady and imemAck in every state.

## Structure
- Shared header instr_fetch.vh holds:
  - `FETCH_IDLE/`FETCH_WAIT/`FETCH_HOLD/`FETCH_DRAIN 2-bit encodings;
  - `FETCH_FAULT_WORD (32'h0).
- Reuse the existing Register sub-module for reqPc and the instWord/instPc output buffer. FSM next-state and output logic stay inline.

## Test plan
- Reset, then memory L=1 returning 32'hDEADBEEF at 64 with instReady=1:
  - imemReq=1 with imemAddr=64 one cycle after release;
  - instWord=32'hDEADBEEF, instPc=64;
  - pcAdvance for exactly 1 cycle;
  - next request at 68.
- L=3 with instReady low for 5 cycles after instValid: instWord/instPc held stable, pcAdvance=0 throughout, and a single pulse when instReady rises.
- flush in FETCH_WAIT at cycle 1 of L=3:
  - imemReq held until ack;
  - data discarded with instValid never 1;
  - next request at the new target pcIn=200.
- flush in the same cycle as imemAck, and separately flush in FETCH_HOLD with instReady=1:
  - no pcAdvance, instValid drops;
  - refetch from the pcIn present in the following cycle.
- pcIn=66 (misaligned): no imemReq, instValid=1 with instFault=1, instWord=0, instPc=66; pcAdvance on accept.
- reset asserted in FETCH_WAIT and in FETCH_DRAIN: every output equals its reset value after one edge; a fresh request at START_PC follows release.
